// File: rtl/id_ex_issue_pkg.sv
// Shared widths, constants and the ID/EX pipeline register layout for the
// decode-to-execute issue stage.
package id_ex_issue_pkg;

   localparam int WORD_BUS      = 32;
   localparam int EX_OP_LOW_BUS = 8;
   localparam int REG_ADDR_BUS  = 5;

   typedef logic [WORD_BUS-1:0]      word_t;
   typedef logic [EX_OP_LOW_BUS-1:0] ex_op_t;
   typedef logic [REG_ADDR_BUS-1:0]  reg_addr_t;

   localparam word_t     ZERO_WORD = '0;
   localparam reg_addr_t ZERO_REG  = '0;
   localparam ex_op_t    EX_NOP    = 8'h00;

   localparam ex_op_t EX_LOGIC_AND = 8'h24;
   localparam ex_op_t EX_LOGIC_OR  = 8'h25;
   localparam ex_op_t EX_LOGIC_XOR = 8'h26;
   localparam ex_op_t EX_LOGIC_NOR = 8'h27;
   localparam ex_op_t EX_LOGIC_LUI = 8'h0f;

   typedef struct packed {
      logic      alu_enable;
      ex_op_t    op;
      word_t     src_left;
      word_t     src_right;
      word_t     store_data;
      reg_addr_t dst;
      logic      write_reg;
      logic      is_load;
   } id_ex_reg_t;

   localparam id_ex_reg_t BUBBLE = '{
      alu_enable: 1'b0, op: EX_NOP, src_left: ZERO_WORD, src_right: ZERO_WORD,
      store_data: ZERO_WORD, dst: ZERO_REG, write_reg: 1'b0, is_load: 1'b0};

   // True when a stage writing dst should bypass the value of register r.
   function automatic logic fwd_hit(logic wr, reg_addr_t dst, reg_addr_t r);
      return wr && (dst == r);
   endfunction

endpackage

// File: rtl/id_ex_issue_if.sv
// Decoded-instruction bundle in, execute operand bundle out, plus the
// stall/flush handshake between ID, the issue stage and EX.
interface id_ex_issue_if;
   import id_ex_issue_pkg::*;

   logic      flush;
   logic      exStall;
   logic      stallReq;

   logic      idValid;
   ex_op_t    idOp;
   reg_addr_t idRs;
   reg_addr_t idRt;
   logic      idReadRs;
   logic      idReadRt;
   logic      idUseImm;
   word_t     idImm;
   reg_addr_t idDst;
   logic      idWriteReg;
   logic      idIsLoad;
   word_t     rsData;
   word_t     rtData;

   word_t     exResult;
   logic      memWriteReg;
   reg_addr_t memDst;
   word_t     memResult;

   logic      aluEnable;
   ex_op_t    op;
   word_t     srcLeft;
   word_t     srcRight;
   word_t     storeData;
   reg_addr_t exDst;
   logic      exWriteReg;
   logic      exIsLoad;

   modport master (
      output flush, exStall, idValid, idOp, idRs, idRt, idReadRs, idReadRt,
             idUseImm, idImm, idDst, idWriteReg, idIsLoad, rsData, rtData,
             exResult, memWriteReg, memDst, memResult,
      input  stallReq, aluEnable, op, srcLeft, srcRight, storeData,
             exDst, exWriteReg, exIsLoad
   );

   modport slave (
      input  flush, exStall, idValid, idOp, idRs, idRt, idReadRs, idReadRt,
             idUseImm, idImm, idDst, idWriteReg, idIsLoad, rsData, rtData,
             exResult, memWriteReg, memDst, memResult,
      output stallReq, aluEnable, op, srcLeft, srcRight, storeData,
             exDst, exWriteReg, exIsLoad
   );

endinterface

// File: rtl/id_ex_issue_operand_forward.sv
// Operand bypass mux for one source register: r0 is hard zero, then the EX
// result, then the MEM result, then register-file data.
module operand_forward
   import id_ex_issue_pkg::*;
(
   input  reg_addr_t i_reg,
   input  word_t     i_rf_data,
   input  logic      i_ex_write,
   input  reg_addr_t i_ex_dst,
   input  word_t     i_ex_result,
   input  logic      i_mem_write,
   input  reg_addr_t i_mem_dst,
   input  word_t     i_mem_result,
   output word_t     o_value
);

   always_comb begin
      o_value = i_rf_data;
      if (i_reg == ZERO_REG)
         o_value = ZERO_WORD;
      else if (fwd_hit(i_ex_write, i_ex_dst, i_reg))
         o_value = i_ex_result;
      else if (fwd_hit(i_mem_write, i_mem_dst, i_reg))
         o_value = i_mem_result;
   end

endmodule

// File: rtl/id_ex_issue.sv
// ID/EX issue stage: resolves operands with EX/MEM forwarding, detects
// load-use hazards and updates the ID/EX register under flush/stall priority.
module id_ex_issue
   import id_ex_issue_pkg::*;
(
   input logic          clk,
   input logic          rst,
   id_ex_issue_if.slave bus
);

   id_ex_reg_t r_idex;
   id_ex_reg_t w_issue;
   word_t      w_rs_val;
   word_t      w_rt_val;
   logic       w_load_use;

   operand_forward u_fwd_rs (
      .i_reg        (bus.idRs),
      .i_rf_data    (bus.rsData),
      .i_ex_write   (r_idex.write_reg),
      .i_ex_dst     (r_idex.dst),
      .i_ex_result  (bus.exResult),
      .i_mem_write  (bus.memWriteReg),
      .i_mem_dst    (bus.memDst),
      .i_mem_result (bus.memResult),
      .o_value      (w_rs_val)
   );

   operand_forward u_fwd_rt (
      .i_reg        (bus.idRt),
      .i_rf_data    (bus.rtData),
      .i_ex_write   (r_idex.write_reg),
      .i_ex_dst     (r_idex.dst),
      .i_ex_result  (bus.exResult),
      .i_mem_write  (bus.memWriteReg),
      .i_mem_dst    (bus.memDst),
      .i_mem_result (bus.memResult),
      .o_value      (w_rt_val)
   );

   // A load in EX has no result yet; a dependent instruction must wait one
   // cycle and pick the data up from MEM.
   assign w_load_use = bus.idValid && r_idex.is_load && (r_idex.dst != ZERO_REG) &&
                       ((bus.idReadRs && (bus.idRs == r_idex.dst)) ||
                        (bus.idReadRt && (bus.idRt == r_idex.dst)));

   assign bus.stallReq = (bus.exStall || w_load_use) && !bus.flush;

   always_comb begin
      w_issue            = BUBBLE;
      w_issue.alu_enable = 1'b1;
      w_issue.op         = bus.idOp;
      w_issue.src_left   = w_rs_val;
      w_issue.src_right  = bus.idUseImm ? bus.idImm : w_rt_val;
      w_issue.store_data = w_rt_val;
      w_issue.dst        = bus.idDst;
      w_issue.write_reg  = bus.idWriteReg;
      w_issue.is_load    = bus.idIsLoad;
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_idex <= BUBBLE;
      else if (bus.flush)
         r_idex <= BUBBLE;
      else if (bus.exStall)
         r_idex <= r_idex;
      else if (w_load_use)
         r_idex <= BUBBLE;
      else if (bus.idValid)
         r_idex <= w_issue;
      else
         r_idex <= BUBBLE;
   end

   assign bus.aluEnable  = r_idex.alu_enable;
   assign bus.op         = r_idex.op;
   assign bus.srcLeft    = r_idex.src_left;
   assign bus.srcRight   = r_idex.src_right;
   assign bus.storeData  = r_idex.store_data;
   assign bus.exDst      = r_idex.dst;
   assign bus.exWriteReg = r_idex.write_reg;
   assign bus.exIsLoad   = r_idex.is_load;

endmodule

// File: tb/tb_id_ex_issue.sv
// Scoreboard bench for id_ex_issue: directed scenarios followed by random
// traffic, checked against a behavioural model of the issue rules.
module tb_id_ex_issue;

   logic clk = 1'b0;
   logic rst;

   id_ex_issue_if bus ();

   id_ex_issue dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic [7:0]  op;
      logic [31:0] left;
      logic [31:0] right;
      logic [31:0] sd;
      logic [4:0]  dst;
      logic        wr;
      logic        ld;
   } exp_t;

   exp_t        q_out[$];
   logic        q_stall[$];
   exp_t        model_ex;
   logic [31:0] rf[32];
   int          errors = 0;
   int          checks = 0;

   function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf_val,
                                           input exp_t ex, input logic [31:0] ex_res,
                                           input logic mem_wr, input logic [4:0] mem_dst,
                                           input logic [31:0] mem_res);
      if (r == 5'd0) return 32'd0;
      if (ex.wr && ex.dst == r) return ex_res;
      if (mem_wr && mem_dst == r) return mem_res;
      return rf_val;
   endfunction

   task automatic step();
      exp_t        nxt;
      logic        lu;
      logic        stall;
      logic [31:0] a;
      logic [31:0] b;
      bus.rsData = rf[bus.idRs];
      bus.rtData = rf[bus.idRt];
      a = resolve(bus.idRs, bus.rsData, model_ex, bus.exResult, bus.memWriteReg, bus.memDst, bus.memResult);
      b = resolve(bus.idRt, bus.rtData, model_ex, bus.exResult, bus.memWriteReg, bus.memDst, bus.memResult);
      lu = bus.idValid && model_ex.ld && (model_ex.dst != 5'd0) &&
           ((bus.idReadRs && bus.idRs == model_ex.dst) || (bus.idReadRt && bus.idRt == model_ex.dst));
      stall = (bus.exStall || lu) && !bus.flush;
      nxt = '0;
      if (rst || bus.flush)
         nxt = '0;
      else if (bus.exStall)
         nxt = model_ex;
      else if (lu)
         nxt = '0;
      else if (bus.idValid) begin
         nxt.en    = 1'b1;
         nxt.op    = bus.idOp;
         nxt.left  = a;
         nxt.right = bus.idUseImm ? bus.idImm : b;
         nxt.sd    = b;
         nxt.dst   = bus.idDst;
         nxt.wr    = bus.idWriteReg;
         nxt.ld    = bus.idIsLoad;
      end
      if (!rst) q_stall.push_back(stall);
      q_out.push_back(nxt);
      model_ex = nxt;
   endtask

   task automatic tick();
      step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      bus.flush = 0; bus.exStall = 0; bus.idValid = 0; bus.idOp = 0;
      bus.idRs = 0; bus.idRt = 0; bus.idReadRs = 0; bus.idReadRt = 0;
      bus.idUseImm = 0; bus.idImm = 0; bus.idDst = 0; bus.idWriteReg = 0;
      bus.idIsLoad = 0; bus.exResult = 0; bus.memWriteReg = 0; bus.memDst = 0;
      bus.memResult = 0;
   endtask

   task automatic issue(input logic [7:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic rrs, input logic rrt, input logic uimm, input logic [31:0] imm,
                        input logic [4:0] dst, input logic wr, input logic ld);
      bus.idValid = 1; bus.idOp = op; bus.idRs = rs; bus.idRt = rt;
      bus.idReadRs = rrs; bus.idReadRt = rrt; bus.idUseImm = uimm; bus.idImm = imm;
      bus.idDst = dst; bus.idWriteReg = wr; bus.idIsLoad = ld;
   endtask

   // Registered outputs: entry pushed in cycle k is due just after edge k+1.
   initial begin
      exp_t e;
      exp_t act;
      forever begin
         @(posedge clk);
         #1;
         if (q_out.size() > 0) begin
            e = q_out.pop_front();
            act = {bus.aluEnable, bus.op, bus.srcLeft, bus.srcRight, bus.storeData,
                   bus.exDst, bus.exWriteReg, bus.exIsLoad};
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL out @%0t act en=%0b op=%h l=%h r=%h sd=%h dst=%0d wr=%0b ld=%0b req en=%0b op=%h l=%h r=%h sd=%h dst=%0d wr=%0b ld=%0b",
                        $time, act.en, act.op, act.left, act.right, act.sd, act.dst, act.wr, act.ld,
                        e.en, e.op, e.left, e.right, e.sd, e.dst, e.wr, e.ld);
            end
         end
      end
   end

   // stallReq is combinational: checked mid-cycle against the same inputs.
   initial begin
      logic s;
      forever begin
         @(negedge clk);
         if (q_stall.size() > 0) begin
            s = q_stall.pop_front();
            checks++;
            if (bus.stallReq !== s) begin
               errors++;
               $display("FAIL stallReq @%0t act=%0b req=%0b", $time, bus.stallReq, s);
            end
         end
      end
   end

   initial begin
      model_ex = '0;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[1] = 32'h0000_00F0;
      rf[2] = 32'h0000_0F00;
      rf[4] = 32'h0000_0077;

      idle();
      rst = 1;
      issue(8'h25, 5'd1, 5'd2, 1, 1, 0, 0, 5'd6, 1, 0);
      tick();
      tick();
      rst = 0;

      issue(8'h25, 5'd1, 5'd2, 1, 1, 0, 0, 5'd6, 1, 0);
      tick();

      issue(8'h20, 5'd1, 5'd2, 1, 1, 0, 0, 5'd3, 1, 0);
      tick();
      bus.exResult = 32'h1234; bus.memWriteReg = 1; bus.memDst = 5'd3; bus.memResult = 32'h5555;
      issue(8'h20, 5'd3, 5'd2, 1, 1, 0, 0, 5'd0, 1, 0);
      tick();
      bus.exResult = 32'h9999; bus.memWriteReg = 1; bus.memDst = 5'd0; bus.memResult = 32'h5555;
      issue(8'h20, 5'd0, 5'd0, 1, 1, 0, 0, 5'd0, 1, 0);
      tick();

      idle();
      issue(8'h23, 5'd1, 5'd0, 1, 0, 1, 32'h4, 5'd5, 1, 1);
      tick();
      issue(8'h25, 5'd5, 5'd2, 1, 1, 0, 0, 5'd7, 1, 0);
      tick();
      bus.memWriteReg = 1; bus.memDst = 5'd5; bus.memResult = 32'hCAFE;
      tick();

      idle();
      issue(8'h26, 5'd1, 5'd2, 1, 1, 0, 0, 5'd8, 1, 0);
      tick();
      bus.exStall = 1;
      issue(8'h24, 5'd2, 5'd1, 1, 1, 0, 0, 5'd9, 1, 0);
      tick();
      bus.flush = 1;
      tick();
      bus.flush = 0;
      tick();
      bus.exStall = 0;

      idle();
      issue(8'h0f, 5'd0, 5'd4, 0, 0, 1, 32'h0000_ABCD, 5'd4, 1, 0);
      tick();

      for (int c = 0; c < 3000; c++) begin
         rst             = ($urandom_range(99) == 0);
         bus.flush       = ($urandom_range(19) == 0);
         bus.exStall     = ($urandom_range(5) == 0);
         bus.idValid     = ($urandom_range(3) != 0);
         bus.idOp        = 8'($urandom);
         bus.idRs        = 5'($urandom_range(7));
         bus.idRt        = 5'($urandom_range(7));
         bus.idReadRs    = 1'($urandom);
         bus.idReadRt    = 1'($urandom);
         bus.idUseImm    = ($urandom_range(3) == 0);
         bus.idImm       = $urandom;
         bus.idDst       = 5'($urandom_range(7));
         bus.idWriteReg  = 1'($urandom);
         bus.idIsLoad    = ($urandom_range(2) == 0);
         bus.exResult    = $urandom;
         bus.memWriteReg = 1'($urandom);
         bus.memDst      = 5'($urandom_range(7));
         bus.memResult   = $urandom;
         if ($urandom_range(7) == 0) rf[$urandom_range(31)] = $urandom;
         tick();
      end

      rst = 0;
      idle();
      @(posedge clk);
      #3;
      checks++;
      if (q_out.size() != 0 || q_stall.size() != 0) begin
         errors++;
         $display("FAIL drain act out=%0d stall=%0d req 0", q_out.size(), q_stall.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

Decode-to-execute issue stage of the toy MIPS pipeline: the producing end of the execute operand interface (`aluEnable`, `op`, `srcLeft`, `srcRight`) consumed by the ALU units. It latches one decoded instruction per cycle into the ID/EX pipeline register and resolves operands by forwarding from EX and MEM. It detects load-use hazards, inserts bubbles, and honours downstream stall and flush.

## Interface
Parameters: none. Widths come from the shared defines: word 32, ex op 8, reg addr 5.
- `clk` in 1: sole clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: squash ID instruction and issue a bubble.
- `exStall` in 1: downstream busy; hold the ID/EX register.
- `idValid` in 1: decoded instruction present.
- `idOp` in 8: ex op (`EX_OP_LOW_BUS`).
- `idRs`, `idRt` in 5 each: source register numbers.
- `idReadRs`, `idReadRt` in 1 each: source actually used.
- `idUseImm` in 1: right operand is the immediate.
- `idImm` in 32: extended immediate.
- `idDst` in 5, `idWriteReg` in 1: destination register and write flag.
- `idIsLoad` in 1: instruction is a load.
- `rsData`, `rtData` in 32 each: register-file read data, combinational from upstream.
- `exResult` in 32: result of the instruction now in EX.
- `memWriteReg` in 1, `memDst` in 5, `memResult` in 32: MEM-stage writeback info, including load data.
- `stallReq` out 1: freeze IF/ID (combinational).
- `aluEnable` out 1: issued slot valid.
- `op` out 8, `srcLeft` out 32, `srcRight` out 32, `storeData` out 32.
- `exDst` out 5, `exWriteReg` out 1, `exIsLoad` out 1.

## Operation
- Operand resolution per source, using `idRs`→left and `idRt`→rt value:
  - Register 0 → 0, never forwarded.
  - Else, if `exWriteReg` && `exDst` == reg → `exResult`.
  - Else, if `memWriteReg` && `memDst` == reg → `memResult`.
  - Else → register-file data.
  - EX match has priority over MEM match.
- `srcRight` = `idUseImm` ? `idImm` : rt value. `storeData` = rt value, always.
- Load-use: `loadUse` = `idValid` && `exIsLoad` && `exDst`≠0 && ((`idReadRs` && `idRs`==`exDst`) || (`idReadRt` && !`idUseImm`... see note) ...). Exact rule: `loadUse` fires when (`idReadRs` && `idRs`==`exDst`) or (`idReadRt` && `idRt`==`exDst`).
- `stallReq` = (`exStall` || `loadUse`) && !`flush`.
- Register update priority, evaluated each edge:
  1. `rst`: all outputs 0.
  2. `flush`: bubble (all outputs 0, op = `EX_NOP` = 0).
  3. `exStall`: hold all registered outputs.
  4. `loadUse`: bubble.
  5. `idValid`: load resolved operands and ID fields.
  6. Otherwise: bubble.
- Bubble = `aluEnable` 0, `exWriteReg` 0, `exIsLoad` 0, `exDst` 0, data 0.
- Two-state view: ISSUE (normal) and HOLD (`exStall`). HOLD→ISSUE when `exStall` drops. `flush` or `rst` exits HOLD immediately, entering ISSUE with a bubble.

## Timing
- Latency: one cycle from ID inputs to registered outputs.
- `stallReq` is combinational, in the same cycle as the hazard.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM and its data is forwarded via `memResult`.
- Simultaneous events:
  - `flush` + `exStall`: flush wins, bubble.
  - `flush` + `loadUse`: bubble, `stallReq` 0.
  - `exStall` + `loadUse`: hold, `stallReq` 1.
- Reset mid-stall clears everything next edge. `stallReq` may be 1 during reset only if inputs demand it; upstream ignores it under `rst`.
- No registered output changes while `exStall` is 1 unless `rst`/`flush`.

## Structure
- Shared define file:
  - `WORD_BUS`, `EX_OP_LOW_BUS`, `REG_ADDR_BUS`
  - `ZERO_WORD`, `ZERO_REG`, `EX_NOP`
  - existing `EX_LOGIC_*` op codes
- Sub-module `operand_forward`: pure mux for reg number, regfile data, EX/MEM match. Instantiated twice (rs, rt).
- Top holds the hazard logic, priority logic and the ID/EX register.

## Test plan
- Reset: `rst`=1 for 2 cycles with `idValid`=1 → all outputs 0, `aluEnable`=0.
- Plain issue: OR, rs=1 (0x00F0), rt=2 (0x0F00) → next cycle `aluEnable`=1, `srcLeft`=0x00F0, `srcRight`=0x0F00.
- Forwarding: EX writes r3=0x1234 while MEM writes r3=0x5555; ID reads r3 → `srcLeft`=0x1234. Repeat with r0 on both → `srcLeft`=0.
- Load-use: load to r5 in EX; ID reads r5 → `stallReq`=1, one bubble. Next cycle `memResult`=0xCAFE for r5 → `srcLeft`=0xCAFE, `stallReq`=0.
- `exStall` held 3 cycles → outputs frozen, `stallReq`=1. Assert `flush` on cycle 2 → bubble issued at that edge.
- LUI immediate: `idUseImm`=1, `idImm`=0xABCD, rt=4 (0x77) → `srcRight`=0xABCD, `storeData`=0x77.
